// File: rtl/imem_boot_loader.sv
// Boot loader: turns a length-prefixed byte stream into 32-bit instruction-memory writes.
// Latency: a word is written in the cycle after its 4th byte; load_done follows one cycle after the last write.
// Backpressure: byte_ready is decoded from state only; it is high while loading and low once DONE or ERR.
module imem_boot_loader #(
    parameter int unsigned          ADDR_W    = 64,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
    parameter int unsigned          DEPTH     = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       word_count
);

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       buf_q, buf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       wc_q, wc_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer;
    logic [15:0]       len_full;
    logic [15:0]       wc_inc;

    // Ready is purely a function of state so it never loops back through byte_valid.
    assign byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
    assign xfer       = byte_valid && byte_ready;
    assign len_full   = {byte_data, len_q[7:0]};
    assign wc_inc     = wc_q + 16'd1;

    // Next-state and datapath updates; every register holds unless its state acts on it.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        lane_d  = lane_q;
        buf_d   = buf_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wc_d    = wc_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = byte_data;
                    state_d    = LEN_HI;
                end
            end

            LEN_HI: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = DONE;
                    end else if (32'(len_full) > DEPTH) begin
                        // Raised on entry so the error is visible in the first ERR cycle.
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                if (xfer) begin
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: buf_d[7:0]   = byte_data;
                        2'd1: buf_d[15:8]  = byte_data;
                        2'd2: buf_d[23:16] = byte_data;
                        default: begin
                            // Top byte completes the word; write it straight from the stream.
                            wdata_d = {byte_data, buf_q};
                            addr_d  = BASE_ADDR + (ADDR_W'(wc_q) << 2);
                            we_d    = 1'b1;
                            wc_d    = wc_inc;
                            if (wc_inc == len_q) begin
                                state_d = DONE;
                            end
                        end
                    endcase
                end
            end

            DONE: begin
                // Set one cycle after entry, which lands just after the final write strobe.
                done_d = 1'b1;
            end

            ERR: begin
                err_d = 1'b1;
            end

            default: begin
                state_d = LEN_LO;
            end
        endcase
    end

    // State register; synchronous reset wins over any in-flight load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LEN_LO;
            len_q   <= '0;
            lane_q  <= '0;
            buf_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            wc_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            lane_q  <= lane_d;
            buf_q   <= buf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wc_q    <= wc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign load_done  = done_q;
    assign load_err   = err_q;
    assign word_count = wc_q;
    // The processor stays in reset until a successful load; an error never releases it.
    assign cpu_reset  = ~done_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sits directly upstream of the RISC-V single-cycle processor.
- Receives a length-prefixed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes those words into instruction memory starting at BASE_ADDR.
- Holds the processor in reset (cpu_reset) until the whole program is loaded, then releases it.

Parameters:
ADDR_W, 64, width of imem_addr; matches the processor PC width.
BASE_ADDR, 0, byte address of the first instruction word.
DEPTH, 256, instruction memory capacity in 32-bit words; largest legal word count.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
byte_valid  input  1  byte_data holds a valid byte.
byte_data  input  8  stream byte.
byte_ready  output  1  loader accepts a byte this cycle.
imem_we  output  1  one-cycle instruction-memory write strobe.
imem_addr  output  ADDR_W  byte address of the write (word aligned).
imem_wdata  output  32  instruction word to write.
cpu_reset  output  1  reset driven to the processor; high until the load completes.
load_done  output  1  load finished successfully (sticky).
load_err  output  1  declared length exceeds DEPTH (sticky).
word_count  output  16  number of words written so far.

Behaviour:
- Handshake: a byte transfers on any edge where byte_valid && byte_ready. byte_ready is a registered/state-decoded output; it never depends combinationally on byte_valid.
- Stream format:
  - Byte 0: N[7:0].
  - Byte 1: N[15:8].
  - Then 4*N instruction bytes, least-significant byte first per word.
- States: LEN_LO, LEN_HI, DATA, DONE, ERR.
- Reset (sync; takes precedence over all other activity, including mid-load):
  - state = LEN_LO.
  - byte_ready = 1, cpu_reset = 1.
  - imem_we = 0, imem_addr = BASE_ADDR, imem_wdata = 0.
  - load_done = 0, load_err = 0, word_count = 0.
  - Byte lane counter = 0, assembly buffer = 0.
- LEN_LO: on transfer, latch N[7:0] and go to LEN_HI.
- LEN_HI: on transfer, latch N[15:8]. Using the full 16-bit N:
  - N == 0 -> DONE.
  - N > DEPTH -> ERR.
  - Otherwise -> DATA.
- DATA: each transfer places the byte into lane 0..3 (2-bit lane counter, wraps 3->0).
  - On the lane-3 transfer, on the same edge:
    - imem_wdata <= {byte_data, buf[23:0]}.
    - imem_addr <= BASE_ADDR + 4*word_count.
    - imem_we <= 1.
    - word_count increments.
  - imem_we is high for exactly one cycle (the cycle after the lane-3 transfer).
  - byte_ready stays high in DATA, so back-to-back bytes at full rate are legal. Peak write rate is one word per 4 cycles.
  - When the incremented word_count equals N, the state becomes DONE on that same edge. byte_ready drops in the following cycle, the same cycle the final imem_we is high.
- DONE:
  - byte_ready = 0.
  - load_done = 1 and cpu_reset = 0, both taking effect in the cycle after the final imem_we pulse (one cycle after entering DONE).
  - For N == 0: load_done = 1 and cpu_reset = 0 in the cycle after entry.
  - Further byte_valid is ignored. Exit only via reset.
- ERR:
  - byte_ready = 0, load_err = 1, cpu_reset stays 1, no writes.
  - Exit only via reset.
- Address arithmetic: unsigned, ADDR_W bits, wraps modulo 2^ADDR_W. It never exceeds BASE_ADDR + 4*(DEPTH-1) because of the N check.
- Stalls: byte_valid may drop in any state without loss. Lane counter and buffer hold their values.
- Reset mid-load: partially assembled words are discarded. Memory contents already written are not cleared. cpu_reset stays 1.

Test Plan:
1. Reset, then stream 02 00 13 05 A0 00 93 05 B0 00 at one byte/cycle -> imem_we pulses twice: addr 0x0 data 0x00A00513, then addr 0x4 data 0x00B00593. load_done = 1 and cpu_reset = 0 the cycle after the second pulse. word_count = 2.
2. Same stream with byte_valid toggled 1,0,1,0 -> identical writes and data. Each pulse is delayed only by the stall cycles. No byte lost or duplicated.
3. Length bytes 00 00 -> no imem_we; load_done = 1 and cpu_reset = 0 in the cycle after LEN_HI accepts. byte_ready = 0 afterwards.
4. Length bytes 01 01 (N = 257 > DEPTH = 256) -> load_err = 1, byte_ready = 0, cpu_reset stays 1, no writes. Length 00 01 (N = 256) with 1024 bytes -> last write at addr 0x3FC, then load_done.
5. Assert reset after 6 data bytes of an N = 2 load -> all outputs return to reset values. Reloading 01 00 13 00 00 00 writes 0x00000013 at addr 0x0.
6. After load_done, drive byte_valid = 1 for 10 cycles -> byte_ready = 0 and imem_we = 0 throughout. word_count and outputs unchanged.
